seq_divider_param: RTL and testbench
====================================

Name: seq_divider_param

Overview:
- Parametrised, iterative fixed-point divider with a start/ready/valid handshake.
- Computes inp1 / inp2 as an integer quotient (oup) plus a fractional part (frac).
- Supports unsigned or two's-complement operation.
- Successor to the fixed-width division_mod. Used in the snell_law datapath, e.g. the sine ratio n1/n2, where one restoring iteration per clock is acceptable.

Parameters:
- WIDTH, 16: width of inp1, inp2 and oup.
- FRAC_W, 16: number of fractional quotient bits in frac; must be ≥1.
- SIGNED, 0: 0 selects unsigned operation; 1 selects two's-complement operands and result.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request a division; accepted only when rfd=1.
- inp1, input, WIDTH: dividend; sampled on the accept edge.
- inp2, input, WIDTH: divisor; sampled on the accept edge.
- rfd, output, 1: ready for data; high when idle.
- valid, output, 1: one-cycle pulse marking oup/frac as new.
- oup, output, WIDTH: integer part of the quotient.
- frac, output, FRAC_W: fractional part of the quotient.
- dbz, output, 1: divide-by-zero flag; present only with DIVIDER_DBZ_EN.

Behaviour:
- Reset values (async, immediate): state=IDLE, rfd=1, valid=0, oup=0, frac=0, dbz=0. All internal registers clear.
- N = WIDTH+FRAC_W iterations.
- States:
  - IDLE: rfd=1. On an edge with start&&rfd:
    - latch operand magnitudes, their signs (when SIGNED) and the divisor-zero condition;
    - clear the partial remainder and the iteration counter;
    - go to CALC; rfd falls on this edge.
  - CALC: one restoring step per edge. Shift the remainder left with the next dividend bit; dividend bits beyond WIDTH shift in as 0. Subtract the divisor magnitude when the remainder ≥ divisor and shift the quotient bit in. After exactly N edges, go to FIX.
  - FIX: one edge.
    - If SIGNED and sign(inp1)^sign(inp2), negate the combined {oup,frac} value as a (WIDTH+FRAC_W)-bit two's-complement number.
    - Register oup/frac, set valid=1 and rfd=1, go to IDLE.
- Latency: valid is high N+1 cycles after the accept edge. Next accept is possible on the edge after valid. Throughput is one result per N+2 cycles.
- valid is exactly one cycle wide. oup/frac hold their value until the next FIX edge.
- start while rfd=0 is ignored; no queuing. Operand changes after the accept edge have no effect.
- Unsigned result: oup=floor(inp1/inp2); frac=floor(frac(inp1/inp2)·2^FRAC_W); truncation, no rounding.
- Signed result: magnitude is computed, then negated. Result is truncated toward zero on the combined fixed-point value.
- Signed overflow, e.g. -2^(WIDTH-1) / -1: magnitude 2^(WIDTH-1) wraps. Result is oup=1 followed by zeros (0x8000 at WIDTH=16), frac=0. No flag.
- Divisor zero: oup and frac are forced to all ones in both modes; sign fix-up is skipped. Latency is unchanged.
- Reset asserted mid-CALC/FIX aborts the operation with no valid pulse. After rst falls, the block is in IDLE with rfd=1.
- start held high continuously: a new operation is accepted on each IDLE cycle.

Optional Feature:
- Macro DIVIDER_DBZ_EN.
- Defined: dbz port exists. dbz is registered on the FIX edge, equal to (latched inp2==0), and held with oup/frac. Reset value is 0.
- Undefined: no dbz port and no dbz logic. Divisor-zero results are still all ones.

Decomposition:
- Package div_pkg holds:
  - state enum: IDLE, CALC, FIX;
  - function clog2 for the iteration counter width, counter width = clog2(N+1);
  - constant for the all-ones divide-by-zero pattern.
- One natural sub-module: div_restore_step. Combinational single restoring iteration: inputs are remainder, next bit and divisor; outputs are next remainder and quotient bit. Parameterised by WIDTH+1.

Test Plan:
- Unsigned basic: inp1=10, inp2=2 → after N+1=33 cycles: valid=1, oup=0x0005, frac=0x0000.
- Unsigned fraction: 10/3 → oup=0x0003, frac=0x5555. 8/2 → 0x0004/0x0000, issued back-to-back on the edge after the first valid.
- SIGNED=1: -10/3 (0xFFF6/0x0003) → oup=0xFFFC, frac=0xAAAB. Also -32768/-1 → oup=0x8000, frac=0x0000.
- Divide by zero: 7/0 → oup=0xFFFF, frac=0xFFFF. With DIVIDER_DBZ_EN: dbz=1; next op 9/3 → dbz=0, oup=3.
- Handshake: start pulsed at cycle 5 of CALC with different operands → ignored. rfd low for exactly 33 cycles. valid high for exactly one cycle.
- Reset mid-CALC: rst at iteration 10 → outputs return to 0, rfd=1, no valid. A fresh 10/2 afterwards yields 5/0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // Wide enough for any practical WIDTH+FRAC_W; sliced down in the top.
  localparam logic [255:0] DBZ_ONES = '1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration on a W-bit remainder.
module div_restore_step #(
  parameter int W = 17
) (
  input  logic [W-1:0] rem,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         qbit
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  always_comb begin
    shifted  = {rem, din};
    qbit     = (shifted >= {1'b0, divisor});
    // Only taken when shifted >= divisor, so the difference fits in W bits.
    diff     = shifted[W-1:0] - divisor;
    rem_next = qbit ? diff : shifted[W-1:0];
  end

endmodule

// File: rtl/seq_divider_param.sv
// Iterative fixed-point divider, one restoring step per clock.
// Optional dbz output enabled by defining DIVIDER_DBZ_EN.
module seq_divider_param
  import div_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FRAC_W = 16,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  inp1,
  input  logic [WIDTH-1:0]  inp2,
  output logic              rfd,
  output logic              valid,
  output logic [WIDTH-1:0]  oup,
  output logic [FRAC_W-1:0] frac
`ifdef DIVIDER_DBZ_EN
  ,
  output logic              dbz
`endif
);

  localparam int N  = WIDTH + FRAC_W;
  localparam int CW = clog2(N + 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg, dvs_reg;
  logic [WIDTH:0]   rem_reg;
  logic [N-1:0]     quo_reg;
  logic [CW-1:0]    cnt_reg;
  logic             neg_reg, dz_reg;

  logic [WIDTH-1:0] mag1, mag2;
  logic             neg_in;
  logic [WIDTH:0]   rem_step;
  logic             q_step;
  logic [N-1:0]     result;

  always_comb begin
    mag1   = inp1;
    mag2   = inp2;
    neg_in = 1'b0;
    if (SIGNED != 0) begin
      mag1   = inp1[WIDTH-1] ? -inp1 : inp1;
      mag2   = inp2[WIDTH-1] ? -inp2 : inp2;
      neg_in = inp1[WIDTH-1] ^ inp2[WIDTH-1];
    end
  end

  div_restore_step #(
    .W(WIDTH + 1)
  ) u_step (
    .rem      (rem_reg),
    .din      (dvd_reg[WIDTH-1]),
    .divisor  ({1'b0, dvs_reg}),
    .rem_next (rem_step),
    .qbit     (q_step)
  );

  // Sign fix-up works on the whole fixed-point value so truncation is toward zero.
  always_comb begin
    if (dz_reg)
      result = DBZ_ONES[N-1:0];
    else if (neg_reg)
      result = -quo_reg;
    else
      result = quo_reg;
  end

  always_comb begin
    state_next = state_reg;
    rfd        = 1'b0;
    case (state_reg)
      IDLE: begin
        rfd = 1'b1;
        if (start) state_next = CALC;
      end
      CALC: if (cnt_reg == CW'(N - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_reg <= '0;
      dvs_reg <= '0;
      rem_reg <= '0;
      quo_reg <= '0;
      cnt_reg <= '0;
      neg_reg <= 1'b0;
      dz_reg  <= 1'b0;
      oup     <= '0;
      frac    <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          dvd_reg <= mag1;
          dvs_reg <= mag2;
          neg_reg <= neg_in;
          dz_reg  <= (inp2 == '0);
          rem_reg <= '0;
          quo_reg <= '0;
          cnt_reg <= '0;
        end
        CALC: begin
          rem_reg <= rem_step;
          quo_reg <= {quo_reg[N-2:0], q_step};
          dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          oup   <= result[N-1:FRAC_W];
          frac  <= result[FRAC_W-1:0];
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DIVIDER_DBZ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 dbz <= 1'b0;
    else if (state_reg == FIX) dbz <= dz_reg;
  end
`endif

endmodule

// File: tb/tb_seq_divider_param.sv
// Self-checking bench: unsigned and signed divider instances vs. an arithmetic model.
module tb_seq_divider_param;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        start;
  logic [1:0][15:0]  inp1, inp2;
  logic [1:0]        rfd, valid, dbz;
  logic [1:0][15:0]  oup, frac;
  int                total = 0;
  int                bad   = 0;

  always #5 clk = ~clk;

  seq_divider_param #(.WIDTH(16), .FRAC_W(16), .SIGNED(0)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start[0]),
    .inp1  (inp1[0]),
    .inp2  (inp2[0]),
    .rfd   (rfd[0]),
    .valid (valid[0]),
    .oup   (oup[0]),
    .frac  (frac[0])
`ifdef DIVIDER_DBZ_EN
    ,
    .dbz   (dbz[0])
`endif
  );

  seq_divider_param #(.WIDTH(16), .FRAC_W(16), .SIGNED(1)) s_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start[1]),
    .inp1  (inp1[1]),
    .inp2  (inp2[1]),
    .rfd   (rfd[1]),
    .valid (valid[1]),
    .oup   (oup[1]),
    .frac  (frac[1])
`ifdef DIVIDER_DBZ_EN
    ,
    .dbz   (dbz[1])
`endif
  );

`ifndef DIVIDER_DBZ_EN
  assign dbz = 2'b00;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Quotient scaled by 2^16, truncated toward zero, as a 32-bit two's-complement value.
  function automatic logic [31:0] model(input int sel, input logic [15:0] a, input logic [15:0] b);
    longint ma, mb, q;
    bit     neg;
    if (b == 16'h0) return 32'hFFFF_FFFF;
    neg = 1'b0;
    if (sel == 1) begin
      ma  = longint'($signed(a));
      mb  = longint'($signed(b));
      neg = (ma < 0) != (mb < 0);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end else begin
      ma = longint'(a);
      mb = longint'(b);
    end
    q = (ma * 65536) / mb;
    if (neg) q = -q;
    return q[31:0];
  endfunction

  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b, input bit glitch);
    logic [31:0] exp;
    int edges, low;
    exp = model(sel, a, b);
    check("rfd_before_start", 32'(rfd[sel]), 32'd1);
    start[sel] = 1'b1;
    inp1[sel]  = a;
    inp2[sel]  = b;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    inp1[sel]  = 16'($urandom);
    inp2[sel]  = 16'($urandom);
    check("valid_one_cycle", 32'(valid[sel]), 32'd0);
    edges = 0;
    low   = 0;
    while (valid[sel] !== 1'b1 && edges < 100) begin
      if (rfd[sel] === 1'b0) low++;
      if (glitch && edges == 5) begin
        start[sel] = 1'b1;
        inp1[sel]  = a + 16'd7;
        inp2[sel]  = b + 16'd1;
      end else begin
        start[sel] = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 32'(edges), 32'd33);
    check("rfd_low_cycles", 32'(low), 32'd33);
    check("oup", 32'(oup[sel]), 32'(exp[31:16]));
    check("frac", 32'(frac[sel]), 32'(exp[15:0]));
    check("rfd_after_valid", 32'(rfd[sel]), 32'd1);
`ifdef DIVIDER_DBZ_EN
    check("dbz", 32'(dbz[sel]), 32'(b == 16'h0));
`endif
    $display("op sel=%0d a=%h b=%h oup=%h frac=%h exp=%h lat=%0d", sel, a, b, oup[sel], frac[sel], exp, edges);
  endtask

  initial begin
    int vcount;
    logic [15:0] ra, rb;
    rst   = 1'b1;
    start = 2'b00;
    inp1  = '0;
    inp2  = '0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_rfd", 32'(rfd[s]), 32'd1);
      check("reset_valid", 32'(valid[s]), 32'd0);
      check("reset_oup", 32'(oup[s]), 32'd0);
      check("reset_frac", 32'(frac[s]), 32'd0);
      check("reset_dbz", 32'(dbz[s]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned directed, including back-to-back issue.
    do_op(0, 16'd10, 16'd2, 1'b0);
    do_op(0, 16'd10, 16'd3, 1'b0);
    do_op(0, 16'd8,  16'd2, 1'b0);
    do_op(0, 16'd7,  16'd0, 1'b0);
    do_op(0, 16'd9,  16'd3, 1'b0);
    do_op(0, 16'd100, 16'd7, 1'b1);
    do_op(0, 16'hFFFF, 16'd1, 1'b0);

    // Signed directed.
    do_op(1, 16'hFFF6, 16'h0003, 1'b0);
    do_op(1, 16'h8000, 16'hFFFF, 1'b0);
    do_op(1, 16'h0007, 16'h0000, 1'b0);
    do_op(1, 16'h0064, 16'hFFF9, 1'b1);

    // Randomized, with occasional zero divisors.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 10; i++) begin
        ra = 16'($urandom);
        rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        do_op(s, ra, rb, 1'b0);
      end
    end

    // Reset in the middle of CALC.
    start[0] = 1'b1;
    inp1[0]  = 16'd1234;
    inp2[0]  = 16'd5;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_oup", 32'(oup[0]), 32'd0);
    check("midrst_frac", 32'(frac[0]), 32'd0);
    check("midrst_rfd", 32'(rfd[0]), 32'd1);
    check("midrst_valid", 32'(valid[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid[0] === 1'b1) vcount++;
    end
    check("midrst_no_valid", 32'(vcount), 32'd0);
    check("midrst_rfd_idle", 32'(rfd[0]), 32'd1);
    do_op(0, 16'd10, 16'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
